// File: rtl/timbre_pkg.sv
// Shared types and default widths for the note oscillator and its envelope.
// Pure declarations: no logic, no latency, no backpressure.
package timbre_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_DECAY,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    localparam int RAMP_W      = 6;
    localparam int DEF_PHASE_W = 24;
    localparam int DEF_GAIN_W  = 8;

endpackage

// File: rtl/env_sat_step.sv
// Saturating envelope step: moves value by step towards limit, clamping at limit.
// Purely combinational (zero latency); no backpressure.
module env_sat_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] step,
    input  logic [W-1:0] limit,
    input  logic         dir_up,
    output logic [W-1:0] result,
    output logic         hit_limit
);

    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum       = {1'b0, value} + {1'b0, step};
        diff      = {1'b0, value} - {1'b0, step};
        result    = value;
        hit_limit = 1'b0;
        if (dir_up) begin
            if (sum >= {1'b0, limit}) begin
                result    = limit;
                hit_limit = 1'b1;
            end else begin
                result = sum[W-1:0];
            end
        end else begin
            // Already at or below the floor: hold the current value rather than jump up to it.
            if (value <= limit) begin
                hit_limit = 1'b1;
            end else if (diff[W] || (diff <= {1'b0, limit})) begin
                result    = limit;
                hit_limit = 1'b1;
            end else begin
                result = diff[W-1:0];
            end
        end
    end

endmodule

// File: rtl/note_osc.sv
// Note oscillator: phase accumulator ramp plus ADSR envelope gain, stepped once per sample tick.
// Latency: outputs registered one cycle after a qualifying tick; no backpressure (o_valid is a pulse).
module note_osc
    import timbre_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int GAIN_W  = DEF_GAIN_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sample_tick,
    input  logic               i_note_on,
    input  logic               i_note_off,
    input  logic [PHASE_W-1:0] i_phase_inc,
    input  logic [GAIN_W-1:0]  i_attack_step,
    input  logic [GAIN_W-1:0]  i_decay_step,
    input  logic [GAIN_W-1:0]  i_release_step,
    input  logic [GAIN_W-1:0]  i_sustain_level,
    output logic [RAMP_W-1:0]  o_ramp,
    output logic [GAIN_W-1:0]  o_gain,
    output logic               o_valid,
    output logic               o_busy
);

    env_state_t         state, state_n;
    logic [PHASE_W-1:0] phase, phase_n;
    logic [PHASE_W-1:0] inc, inc_n;
    logic [GAIN_W-1:0]  gain, gain_n;
    logic               valid_n;

    logic [GAIN_W-1:0]  raw_step;
    logic [GAIN_W-1:0]  eff_step;
    logic [GAIN_W-1:0]  step_limit;
    logic               step_up;
    logic [GAIN_W-1:0]  step_res;
    logic               step_hit;
    logic               off_event;

    always_comb begin
        raw_step   = i_attack_step;
        step_limit = '1;
        step_up    = 1'b1;
        case (state)
            ENV_DECAY: begin
                raw_step   = i_decay_step;
                step_limit = i_sustain_level;
                step_up    = 1'b0;
            end
            ENV_RELEASE: begin
                raw_step   = i_release_step;
                step_limit = '0;
                step_up    = 1'b0;
            end
            default: ;
        endcase
        // A zero slope would freeze the envelope forever, so it is promoted to 1.
        eff_step = (raw_step == '0) ? {{(GAIN_W-1){1'b0}}, 1'b1} : raw_step;
    end

    env_sat_step #(
        .W(GAIN_W)
    ) u_step (
        .value    (gain),
        .step     (eff_step),
        .limit    (step_limit),
        .dir_up   (step_up),
        .result   (step_res),
        .hit_limit(step_hit)
    );

    assign off_event = i_note_off &&
                       (state == ENV_ATTACK || state == ENV_DECAY || state == ENV_SUSTAIN);

    always_comb begin
        state_n = state;
        phase_n = phase;
        inc_n   = inc;
        gain_n  = gain;
        valid_n = 1'b0;
        if (i_note_on) begin
            state_n = ENV_ATTACK;
            inc_n   = i_phase_inc;
            if (state == ENV_IDLE) begin
                phase_n = '0;
                gain_n  = '0;
            end
        end else if (off_event) begin
            state_n = ENV_RELEASE;
        end else if (i_sample_tick && state != ENV_IDLE) begin
            phase_n = phase + inc;
            valid_n = 1'b1;
            case (state)
                ENV_ATTACK: begin
                    gain_n = step_res;
                    if (step_hit) state_n = ENV_DECAY;
                end
                ENV_DECAY: begin
                    gain_n = step_res;
                    if (step_hit) state_n = ENV_SUSTAIN;
                end
                ENV_RELEASE: begin
                    gain_n = step_res;
                    if (step_hit) begin
                        state_n = ENV_IDLE;
                        phase_n = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ENV_IDLE;
            phase   <= '0;
            inc     <= '0;
            gain    <= '0;
            o_ramp  <= '0;
            o_gain  <= '0;
            o_valid <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            inc     <= inc_n;
            gain    <= gain_n;
            o_valid <= valid_n;
            if (valid_n) begin
                o_ramp <= phase_n[PHASE_W-1 -: RAMP_W];
                o_gain <= gain_n;
            end
        end
    end

    assign o_busy = (state != ENV_IDLE);

endmodule

// File: tb/tb_note_osc.sv
// Directed bench for note_osc: stimulus pushes hand-computed {ramp, gain} into a queue,
// a monitor pops and compares on every o_valid pulse.
module tb_note_osc;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_sample_tick = 1'b0;
    logic        i_note_on = 1'b0;
    logic        i_note_off = 1'b0;
    logic [23:0] i_phase_inc = '0;
    logic [7:0]  i_attack_step = '0;
    logic [7:0]  i_decay_step = '0;
    logic [7:0]  i_release_step = '0;
    logic [7:0]  i_sustain_level = '0;
    logic [5:0]  o_ramp;
    logic [7:0]  o_gain;
    logic        o_valid;
    logic        o_busy;

    int total = 0;
    int bad = 0;
    logic [13:0] exp_q [$];

    note_osc #(
        .PHASE_W(24),
        .GAIN_W (8)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_sample_tick  (i_sample_tick),
        .i_note_on      (i_note_on),
        .i_note_off     (i_note_off),
        .i_phase_inc    (i_phase_inc),
        .i_attack_step  (i_attack_step),
        .i_decay_step   (i_decay_step),
        .i_release_step (i_release_step),
        .i_sustain_level(i_sustain_level),
        .o_ramp         (o_ramp),
        .o_gain         (o_gain),
        .o_valid        (o_valid),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Monitor: every valid pulse must match the oldest expected entry.
    initial begin
        logic [13:0] e;
        forever begin
            @(negedge i_clk);
            if (o_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid: got ramp=%0d gain=%0d, required no output", o_ramp, o_gain);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_ramp, o_gain} !== e) begin
                        bad++;
                        $display("FAIL sample: got ramp=%0d gain=%0d, required ramp=%0d gain=%0d",
                                 o_ramp, o_gain, e[13:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic tick(input logic [5:0] r, input logic [7:0] g);
        exp_q.push_back({r, g});
        i_sample_tick = 1'b1;
        cyc();
        i_sample_tick = 1'b0;
    endtask

    task automatic idle_tick();
        i_sample_tick = 1'b1;
        cyc();
        i_sample_tick = 1'b0;
    endtask

    task automatic note(input logic on, input logic off, input logic [23:0] inc, input logic with_tick);
        i_note_on     = on;
        i_note_off    = off;
        i_phase_inc   = inc;
        i_sample_tick = with_tick;
        cyc();
        i_note_on     = 1'b0;
        i_note_off    = 1'b0;
        i_sample_tick = 1'b0;
    endtask

    initial begin
        logic [7:0] ga [5] = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd155};

        i_rst = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b0;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ramp", o_ramp, 0);
        chk("rst_gain", o_gain, 0);

        idle_tick();
        cyc();
        chk("idle_busy", o_busy, 0);

        // Ramp wrap and attack/decay/sustain shape.
        i_attack_step = 8'd64; i_decay_step = 8'd100; i_sustain_level = 8'd100;
        note(1'b1, 1'b0, 24'h040000, 1'b0);
        chk("on_busy", o_busy, 1);
        for (int k = 1; k <= 70; k++)
            tick(6'(k), (k <= 5) ? ga[k-1] : 8'd100);

        // Release to zero returns to idle with the phase cleared.
        i_release_step = 8'd50;
        note(1'b0, 1'b1, 24'h040000, 1'b0);
        chk("rel_busy", o_busy, 1);
        tick(6'd7, 8'd50);
        tick(6'd0, 8'd0);
        chk("rel_done_busy", o_busy, 0);
        idle_tick();
        idle_tick();
        idle_tick();
        cyc();

        // Retrigger from release keeps gain and phase, takes the new increment.
        i_attack_step = 8'd128;
        note(1'b1, 1'b0, 24'h040000, 1'b0);
        tick(6'd1, 8'd128);
        tick(6'd2, 8'd255);
        tick(6'd3, 8'd155);
        tick(6'd4, 8'd100);
        note(1'b0, 1'b1, 24'h040000, 1'b0);
        tick(6'd5, 8'd50);
        i_attack_step = 8'd100;
        note(1'b1, 1'b0, 24'h080000, 1'b0);
        tick(6'd7, 8'd150);
        tick(6'd9, 8'd250);
        tick(6'd11, 8'd255);
        tick(6'd13, 8'd155);
        tick(6'd15, 8'd100);
        tick(6'd17, 8'd100);

        // Reset in sustain wins over a coincident note_on and tick.
        i_rst = 1'b1;
        note(1'b1, 1'b0, 24'h040000, 1'b1);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_ramp", o_ramp, 0);
        chk("midrst_gain", o_gain, 0);
        i_rst = 1'b0;
        cyc();

        // note_on and note_off together from idle: attack, not release.
        i_attack_step = 8'd64; i_release_step = 8'd50;
        note(1'b1, 1'b1, 24'h040000, 1'b0);
        chk("onoff_busy", o_busy, 1);
        tick(6'd1, 8'd64);
        // A tick coinciding with a note event produces no sample.
        note(1'b0, 1'b1, 24'h040000, 1'b1);
        tick(6'd2, 8'd14);
        tick(6'd0, 8'd0);
        chk("onoff_done_busy", o_busy, 0);

        // Zero slopes are treated as one.
        i_attack_step = 8'd0; i_decay_step = 8'd0; i_sustain_level = 8'd250;
        note(1'b1, 1'b0, 24'h040000, 1'b0);
        for (int k = 1; k <= 255; k++)
            tick(6'(k), 8'(k));
        tick(6'd0, 8'd254);
        tick(6'd1, 8'd253);

        cyc();
        cyc();
        cyc();
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
